// File: rtl/fft32_pkg.sv
// Shared fft32 datapath widths and the result record passed between
// the product rounding stage and the next butterfly stage.
package fft32_pkg;

  localparam int SAMPLE_W = 14;
  localparam int PROD_W   = 26;
  localparam int TW_SHIFT = 12;
  localparam int FFT_N    = 32;

  typedef struct packed {
    logic                sat;
    logic [SAMPLE_W-1:0] data;
  } result_t;

endpackage

// File: rtl/fft32_skid2.sv
// Two-entry valid/ready FIFO of result_t. The ready flag is a flop so the
// upstream never sees a combinational path from the downstream ready.
module fft32_skid2
  import fft32_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  result_t push_data,
  output logic    push_ready,
  input  logic    pop,
  output logic    pop_valid,
  output result_t head
);

  result_t    mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic       do_push;
  logic       do_pop;

  assign do_push   = push && push_ready;
  assign do_pop    = pop && pop_valid;
  assign pop_valid = (cnt != 2'd0);
  assign head      = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      cnt        <= 2'd0;
      push_ready <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt        <= cnt_nxt;
      push_ready <= (cnt_nxt != 2'd2);
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fft32_prod_round_buf.sv
// Rounds, shifts and saturates twiddle products to sample width, buffers
// them in a 2-entry FIFO and marks the last sample of every frame.
module fft32_prod_round_buf
  import fft32_pkg::*;
#(
  parameter int IN_W      = PROD_W,
  parameter int OUT_W     = SAMPLE_W,
  parameter int SHIFT     = TW_SHIFT,
  parameter int FRAME_LEN = FFT_N
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_last,
  output logic             sat_sticky,
  input  logic             sat_clr
);

  localparam int            CNT_W = $clog2(FRAME_LEN);
  localparam logic [IN_W:0] RND   = (IN_W+1)'(1) << (SHIFT-1);
  localparam logic [IN_W:0] MAXV  = (IN_W+1)'((1 << OUT_W) - 1);

  // One extra bit on the sum keeps the rounding add from wrapping.
  function automatic result_t round_sat(input logic [IN_W-1:0] d);
    logic [IN_W:0] sum;
    logic [IN_W:0] q;
    result_t       r;
    sum = {1'b0, d} + RND;
    q   = sum >> SHIFT;
    if (q > MAXV) begin
      r.sat  = 1'b1;
      r.data = '1;
    end else begin
      r.sat  = 1'b0;
      r.data = q[OUT_W-1:0];
    end
    return r;
  endfunction

  // Stage p0: rounding is combinational ahead of the FIFO write.
  result_t rnd_p0;
  logic    vld_p0;

  assign rnd_p0 = round_sat(in_data);
  assign vld_p0 = in_valid && in_ready;

  // Stage p1: FIFO head drives the output port.
  result_t          head_p1;
  logic             vld_p1;
  logic             pop_p1;
  logic [CNT_W-1:0] frame_cnt;

  fft32_skid2 u_fifo (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .push       (in_valid),
    .push_data  (rnd_p0),
    .push_ready (in_ready),
    .pop        (out_ready),
    .pop_valid  (vld_p1),
    .head       (head_p1)
  );

  assign pop_p1    = vld_p1 && out_ready;
  assign out_valid = vld_p1;
  assign out_data  = vld_p1 ? head_p1.data : '0;
  assign out_sat   = vld_p1 && head_p1.sat;
  assign out_last  = vld_p1 && (frame_cnt == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      frame_cnt  <= '0;
      sat_sticky <= 1'b0;
    end else begin
      if (pop_p1) frame_cnt <= frame_cnt + CNT_W'(1);
      if (vld_p0 && rnd_p0.sat) sat_sticky <= 1'b1;
      else if (sat_clr)         sat_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft32_prod_round_buf.sv
// Directed and randomized bench for fft32_prod_round_buf against a queue
// model of the FIFO with arithmetic rounding/saturation.
module tb_fft32_prod_round_buf;

  typedef struct packed {
    logic        s;
    logic [13:0] d;
  } exp_t;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_data;
  logic        out_sat;
  logic        out_last;
  logic        sat_sticky;
  logic        sat_clr;

  fft32_prod_round_buf dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_last   (out_last),
    .sat_sticky (sat_sticky),
    .sat_clr    (sat_clr)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t mq[$];
  int   m_cnt    = 0;
  logic m_sticky = 1'b0;
  logic acc_last;
  int   n_pop    = 0;
  int   n_last_obs = 0;
  int   last_idx[$];

  function automatic exp_t ref_round(input logic [25:0] d);
    int unsigned q;
    exp_t e;
    q = (32'(d) + 32'd2048) / 32'd4096;
    if (q > 32'd16383) begin
      e.s = 1'b1;
      e.d = 14'h3FFF;
    end else begin
      e.s = 1'b0;
      e.d = q[13:0];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives inputs, checks outputs, advances one cycle.
  task automatic cycle(input logic iv, input logic [25:0] id, input logic ordy, input logic clr);
    exp_t hd;
    logic pop;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    sat_clr   = clr;
    #1;
    hd = (mq.size() != 0) ? mq[0] : '0;
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("out_data", 32'(out_data), 32'(hd.d));
    chk("out_sat", 32'(out_sat), 32'(hd.s));
    chk("out_last", 32'(out_last), 32'((mq.size() != 0) && (m_cnt == 31)));
    chk("sat_sticky", 32'(sat_sticky), 32'(m_sticky));
    acc_last = iv && (mq.size() < 2);
    pop      = (mq.size() != 0) && ordy;
    if (pop && out_last) begin
      n_last_obs++;
      last_idx.push_back(n_pop);
    end
    @(posedge ap_clk);
    if (pop) begin
      void'(mq.pop_front());
      m_cnt = (m_cnt + 1) % 32;
      n_pop++;
    end
    if (acc_last) begin
      hd = ref_round(id);
      mq.push_back(hd);
    end
    if (acc_last && hd.s) m_sticky = 1'b1;
    else if (clr)         m_sticky = 1'b0;
    @(negedge ap_clk);
  endtask

  task automatic send(input logic [25:0] d, input logic ordy);
    int k;
    k = 0;
    acc_last = 1'b0;
    while (!acc_last && k < 50) begin
      cycle(1'b1, d, ordy, 1'b0);
      k++;
    end
    if (!acc_last) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (mq.size() != 0 && k < 20) begin
      cycle(1'b0, 26'd0, 1'b1, 1'b0);
      k++;
    end
    if (mq.size() != 0) chk("drain_timeout", 32'(mq.size()), 32'd0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sat_clr   = 1'b0;
    ap_rst_n  = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_sticky", 32'(sat_sticky), 32'd0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    mq.delete();
    m_cnt    = 0;
    m_sticky = 1'b0;
    n_pop    = 0;
  endtask

  task automatic one_shot(input string tag, input logic [25:0] d, input logic [13:0] ed, input logic es);
    cycle(1'b1, d, 1'b0, 1'b0);
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_sat"}, 32'(out_sat), 32'(es));
    cycle(1'b0, 26'd0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [25:0] pend;
    logic        have;
    int          acc_n;
    int          k;
    int          t0;

    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    sat_clr   = 1'b0;
    repeat (2) @(negedge ap_clk);
    do_reset();

    // Rounding boundary around one LSB
    one_shot("t1_half", 26'h0000800, 14'h0001, 1'b0);
    one_shot("t1_below", 26'h00007FF, 14'h0000, 1'b0);

    // Saturation boundary
    one_shot("t2_max", 26'h3FFF000, 14'h3FFF, 1'b0);
    chk("t2_sticky0", 32'(sat_sticky), 32'd0);
    one_shot("t2_over", 26'h3FFF800, 14'h3FFF, 1'b1);
    one_shot("t2_top", 26'h3FFFFFF, 14'h3FFF, 1'b1);
    chk("t2_sticky1", 32'(sat_sticky), 32'd1);
    cycle(1'b0, 26'd0, 1'b0, 1'b1);
    chk("t2_clr", 32'(sat_sticky), 32'd0);

    // Back-pressure: two accepted, third held until space frees up
    cycle(1'b1, 26'h0011000, 1'b0, 1'b0);
    cycle(1'b1, 26'h0022000, 1'b0, 1'b0);
    chk("t3_full", 32'(in_ready), 32'd0);
    cycle(1'b1, 26'h0033000, 1'b0, 1'b0);
    chk("t3_held", 32'(acc_last), 32'd0);
    chk("t3_head", 32'(out_data), 32'h0011);
    send(26'h0033000, 1'b1);
    drain();
    chk("t3_count", 32'(n_pop), 32'd8);

    // Streaming: one per cycle, last on outputs 31 and 63
    do_reset();
    n_last_obs = 0;
    last_idx.delete();
    t0 = $time;
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 26'($urandom), 1'b1, 1'b0);
      chk("t4_accept", 32'(acc_last), 32'd1);
    end
    drain();
    chk("t4_cycles", 32'(($time - t0) / 10), 32'd65);
    chk("t4_nlast", 32'(n_last_obs), 32'd2);
    if (last_idx.size() == 2) begin
      chk("t4_last0", 32'(last_idx[0]), 32'd31);
      chk("t4_last1", 32'(last_idx[1]), 32'd63);
    end else chk("t4_lastq", 32'(last_idx.size()), 32'd2);

    // Random traffic against the model
    do_reset();
    acc_n = 0;
    have  = 1'b0;
    pend  = '0;
    k     = 0;
    while (acc_n < 1000 && k < 20000) begin
      if (!have && ($urandom_range(0, 1) == 1)) begin
        if ($urandom_range(0, 3) == 0) pend = 26'h3FFC000 | 26'($urandom_range(0, 16383));
        else                           pend = 26'($urandom);
        have = 1'b1;
      end
      cycle(have, pend, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      if (acc_last) begin
        have = 1'b0;
        acc_n++;
      end
      k++;
    end
    chk("t5_done", 32'(acc_n), 32'd1000);
    drain();

    // Reset mid-frame with the FIFO full
    do_reset();
    send(26'h3FFFFFF, 1'b1);
    k = 0;
    while (n_pop < 10 && k < 100) begin
      cycle(1'b1, 26'($urandom), 1'b1, 1'b0);
      k++;
    end
    k = 0;
    while (mq.size() < 2 && k < 10) begin
      cycle(1'b1, 26'($urandom), 1'b0, 1'b0);
      k++;
    end
    chk("t6_full", 32'(in_ready), 32'd0);
    chk("t6_sticky_pre", 32'(sat_sticky), 32'd1);
    do_reset();
    chk("t6_sticky_post", 32'(sat_sticky), 32'd0);
    n_last_obs = 0;
    last_idx.delete();
    for (int i = 0; i < 32; i++) send(26'($urandom) & 26'h1FFFFFF, 1'b1);
    drain();
    chk("t6_last_idx", (last_idx.size() == 1) ? 32'(last_idx[0]) : 32'hFFFF, 32'd31);
    cycle(1'b1, 26'h3FFFFFF, 1'b1, 1'b1);
    chk("t6_set_wins", 32'(sat_sticky), 32'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
